// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a selectable registered or first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int unsigned DataWidth      = 8,
  parameter int unsigned Depth          = 16,
  parameter int unsigned PtrWidth       = $clog2(Depth),
  parameter int unsigned AlmostFullThr  = Depth - 2,
  parameter int unsigned AlmostEmptyThr = 2,
  parameter bit          Fwft           = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 writeEn,
  input  logic [DataWidth-1:0] writeData,
  input  logic                 readEn,
  input  logic                 clearErr,
  output logic [DataWidth-1:0] readData,
  output logic                 readValid,
  output logic                 full,
  output logic                 empty,
  output logic                 almostFull,
  output logic                 almostEmpty,
  output logic [PtrWidth:0]    count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned CntW = PtrWidth + 1;
  localparam logic [PtrWidth:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrWidth:0] AfCnt    = CntW'(AlmostFullThr);
  localparam logic [PtrWidth:0] AeCnt    = CntW'(AlmostEmptyThr);
  localparam logic [PtrWidth:0] One      = CntW'(1);

  logic [DataWidth-1:0] mem_q [Depth];

  logic [PtrWidth:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrWidth:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrWidth:0]    count_q, count_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 wr_acc, rd_acc;
  logic [PtrWidth-1:0]  wr_idx, rd_idx;
  logic [DataWidth-1:0] head;

  assign wr_idx = wr_ptr_q[PtrWidth-1:0];
  assign rd_idx = rd_ptr_q[PtrWidth-1:0];
  assign head   = mem_q[rd_idx];

  // Acceptance uses the registered flags, so a rejected request never touches state.
  assign wr_acc = writeEn & ~full;
  assign rd_acc = readEn & ~empty;

  always_comb begin
    wr_ptr_d   = wr_acc ? wr_ptr_q + One : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + One : rd_ptr_q;
    count_d    = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clearErr keeps the flag set.
    ovf_d      = (writeEn & full) | (ovf_q & ~clearErr);
    unf_d      = (readEn & empty) | (unf_q & ~clearErr);
    rd_data_d  = rd_acc ? head : rd_data_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_idx] <= writeData;
    end
  end

  always_comb begin
    full        = (count_q == DepthCnt);
    empty       = (count_q == '0);
    almostFull  = (count_q >= AfCnt);
    almostEmpty = (count_q <= AeCnt);
    count       = count_q;
    overflow    = ovf_q;
    underflow   = unf_q;
    // FWFT shows the head combinationally; when empty it holds the last popped word.
    if (Fwft) begin
      readValid = ~empty;
      readData  = empty ? rd_data_q : head;
    end else begin
      readValid = rd_valid_q;
      readData  = rd_data_q;
    end
  end

endmodule
